// File: rtl/fsm_sched_pkg.sv
// ---------------------------------------------------------------------------
// fsm_sched_pkg
//   Shared definitions for the round-robin sequencer scheduler.
//   Contents:
//     state_t   2-bit scheduler state (IDLE / RUN / DONE, 2'b11 unused)
//     STATE_W   width of the state encoding
// ---------------------------------------------------------------------------
package fsm_sched_pkg;

    localparam int STATE_W = 2;

    // 2'b11 is deliberately left unencoded; the FSM falls back to IDLE on it.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage : fsm_sched_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches req starting at index ptr,
//   wrapping modulo N_REQ, and returns the first set requester.
//   Ports:
//     req     in   N_REQ           request vector
//     ptr     in   clog2(N_REQ)    search start index (always < N_REQ)
//     valid   out  1               at least one request is set
//     winner  out  clog2(N_REQ)    index of the selected requester
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] winner
);

    localparam int IW = $clog2(N_REQ);

    // Request vector rotated so that position 0 corresponds to ptr.
    logic [N_REQ-1:0] rot_req;
    logic [IW-1:0]    rot_idx [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            // One extra bit so ptr+gi cannot overflow before the wrap check;
            // explicit subtract keeps non-power-of-2 N_REQ correct.
            logic [IW:0] sum;
            assign sum          = {1'b0, ptr} + (IW+1)'(gi);
            assign rot_idx[gi]  = (sum >= (IW+1)'(N_REQ)) ?
                                  IW'(sum - (IW+1)'(N_REQ)) : sum[IW-1:0];
            assign rot_req[gi]  = req[rot_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the lowest rotated position is written last
    // and therefore wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                valid  = 1'b1;
                winner = rot_idx[k];
            end
        end
    end

endmodule : rr_pick

// File: rtl/fsm_rr_scheduler.sv
// ---------------------------------------------------------------------------
// fsm_rr_scheduler
//   Shares a single 4-phase sequencer between N_REQ requesters. A round-robin
//   winner owns the sequencer for JOB_LEN cycles (RUN), then a one-cycle DONE
//   pulse is issued and the pointer advances past the winner. A job ends
//   early (aborted) if the owner drops its request while running.
//   Ports:
//     clk        in   1               rising-edge clock
//     reset      in   1               synchronous, active-high
//     req        in   N_REQ           level request per requester
//     req_x1     in   N_REQ           per-requester x1 value for its job
//     gnt        out  N_REQ           one-hot grant, zero outside RUN
//     gnt_id     out  clog2(N_REQ)    index of current/last winner
//     seq_start  out  1               pulse in the first RUN cycle
//     seq_x1     out  1               latched x1 of the winner
//     busy       out  1               high during RUN
//     done       out  1               pulse in DONE
//     aborted    out  1               qualifies done: job ended early
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module fsm_rr_scheduler
    import fsm_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int JOB_LEN = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_x1,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     seq_start,
    output logic                     seq_x1,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted
);

    localparam int IW = $clog2(N_REQ);
    // JOB_LEN=1 would give a zero-width counter; keep at least one bit.
    localparam int CW = (JOB_LEN > 1) ? $clog2(JOB_LEN) : 1;

    localparam logic [CW-1:0] CNT_INIT = CW'(JOB_LEN - 1);
    localparam logic [IW-1:0] LAST_ID  = IW'(N_REQ - 1);

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    state_t             state_reg,     state_next;
    logic [CW-1:0]      cnt_reg,       cnt_next;
    logic [IW-1:0]      ptr_reg,       ptr_next;
    logic [N_REQ-1:0]   gnt_reg,       gnt_next;
    logic [IW-1:0]      gnt_id_reg,    gnt_id_next;
    logic               seq_start_reg, seq_start_next;
    logic               seq_x1_reg,    seq_x1_next;
    logic               busy_reg,      busy_next;
    logic               done_reg,      done_next;
    logic               aborted_reg,   aborted_next;

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [N_REQ-1:0]   pick_onehot;
    logic [IW-1:0]      ptr_after;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == IW'(gi));
        end
    endgenerate

    // Next search start: one past the current owner, wrapping at N_REQ-1.
    assign ptr_after = (gnt_id_reg == LAST_ID) ? '0 : gnt_id_reg + IW'(1);

    // ---------------------------------------------------------------------
    // Sequential part
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            ptr_reg       <= '0;
            gnt_reg       <= '0;
            gnt_id_reg    <= '0;
            seq_start_reg <= 1'b0;
            seq_x1_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ptr_reg       <= ptr_next;
            gnt_reg       <= gnt_next;
            gnt_id_reg    <= gnt_id_next;
            seq_start_reg <= seq_start_next;
            seq_x1_reg    <= seq_x1_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            aborted_reg   <= aborted_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and next-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        ptr_next       = ptr_reg;
        gnt_next       = gnt_reg;
        gnt_id_next    = gnt_id_reg;
        seq_start_next = 1'b0;
        seq_x1_next    = seq_x1_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        aborted_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                gnt_next  = '0;
                busy_next = 1'b0;
                if (pick_valid) begin
                    state_next     = ST_RUN;
                    gnt_next       = pick_onehot;
                    gnt_id_next    = pick_idx;
                    seq_x1_next    = req_x1[pick_idx];
                    seq_start_next = 1'b1;
                    busy_next      = 1'b1;
                    cnt_next       = CNT_INIT;
                end
            end

            ST_RUN: begin
                cnt_next = (cnt_reg != '0) ? cnt_reg - CW'(1) : '0;
                // Owner dropping its request wins over normal expiry, so a
                // drop in the last RUN cycle is still reported as an abort.
                if (!req[gnt_id_reg] || (cnt_reg == '0)) begin
                    state_next   = ST_DONE;
                    done_next    = 1'b1;
                    aborted_next = !req[gnt_id_reg];
                    gnt_next     = '0;
                    busy_next    = 1'b0;
                    seq_x1_next  = 1'b0;
                    ptr_next     = ptr_after;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next  = ST_IDLE;
                gnt_next    = '0;
                busy_next   = 1'b0;
                seq_x1_next = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign seq_start = seq_start_reg;
    assign seq_x1    = seq_x1_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign aborted   = aborted_reg;

endmodule : fsm_rr_scheduler

// File: tb/tb_fsm_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fsm_rr_scheduler
//   Directed stimulus with hand-computed job schedules. Each issued job
//   pushes its expected start and done events into a scoreboard queue; a
//   negedge monitor pops and compares whenever seq_start or done appears.
//   Cycle k is the interval following the k-th rising clock edge.
// ---------------------------------------------------------------------------
module tb_fsm_rr_scheduler;

    localparam int N_REQ   = 4;
    localparam int JOB_LEN = 4;

    logic             clk;
    logic             reset;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] req_x1;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       gnt_id;
    logic             seq_start;
    logic             seq_x1;
    logic             busy;
    logic             done;
    logic             aborted;

    fsm_rr_scheduler #(
        .N_REQ   (N_REQ),
        .JOB_LEN (JOB_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_x1    (req_x1),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .seq_start (seq_start),
        .seq_x1    (seq_x1),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int is_done;
        int id;
        int x1;
        int ab;
        int cyc;
        int run_len;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_job(input int id, input int x1, input int st,
                            input int run_len, input int ab, input bit with_done);
        exp_t e;
        e.is_done = 0; e.id = id; e.x1 = x1; e.ab = 0; e.cyc = st; e.run_len = 0;
        sb.push_back(e);
        $display("issue job: id=%0d x1=%0d start@%0d len=%0d ab=%0d done=%0d",
                 id, x1, st, run_len, ab, with_done);
        if (with_done) begin
            e.is_done = 1; e.ab = ab; e.cyc = st + run_len; e.run_len = run_len;
            sb.push_back(e);
        end
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------------------------------------------------------------
    // Monitor / scoreboard checker
    // ---------------------------------------------------------------------
    int run_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] exp_gnt;

        chk("busy_vs_gnt", 32'(busy), 32'(gnt != '0));

        if (seq_start === 1'b1) begin
            if (sb.size() == 0 || sb[0].is_done != 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_start: gnt=%b gnt_id=%0d at cycle %0d, no start expected",
                         gnt, gnt_id, cyc);
            end else begin
                e = sb.pop_front();
                exp_gnt = 32'd1 << e.id;
                chk("start_cycle", 32'(cyc), 32'(e.cyc));
                chk("gnt", 32'(gnt), exp_gnt);
                chk("gnt_id", 32'(gnt_id), 32'(e.id));
                chk("seq_x1", 32'(seq_x1), 32'(e.x1));
                $display("start: cycle=%0d gnt=%b gnt_id=%0d seq_x1=%0b", cyc, gnt, gnt_id, seq_x1);
            end
            run_cnt = 0;
        end

        if (busy === 1'b1) run_cnt++;

        if (done === 1'b1) begin
            if (sb.size() == 0 || sb[0].is_done == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: gnt_id=%0d aborted=%0b at cycle %0d, no done expected",
                         gnt_id, aborted, cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("done_gnt_id", 32'(gnt_id), 32'(e.id));
                chk("aborted", 32'(aborted), 32'(e.ab));
                chk("run_len", 32'(run_cnt), 32'(e.run_len));
                $display("done: cycle=%0d gnt_id=%0d aborted=%0b run_len=%0d",
                         cyc, gnt_id, aborted, run_cnt);
            end
        end else begin
            chk("aborted_idle", 32'(aborted), 32'd0);
        end

        if (busy !== 1'b1) run_cnt = 0;
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        reset  = 1'b1;
        req    = 4'b1111;
        req_x1 = 4'b1010;

        // Reset held for two edges with all requests asserted.
        wait_cycle(2);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_seq_start", 32'(seq_start), 32'd0);
        chk("rst_seq_x1", 32'(seq_x1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);

        // Round robin with req=1111 held: starts 6 cycles apart.
        push_job(0, 0,  3, 4, 0, 1'b1);
        push_job(1, 1,  9, 4, 0, 1'b1);
        push_job(2, 0, 15, 4, 0, 1'b1);
        push_job(3, 1, 21, 4, 0, 1'b1);
        push_job(0, 0, 27, 4, 0, 1'b1);
        reset = 1'b0;

        wait_cycle(31);
        req = 4'b0000;

        // Single job from ptr=1: requester 2 only.
        wait_cycle(33);
        req    = 4'b0100;
        req_x1 = 4'b0100;
        push_job(2, 1, 34, 4, 0, 1'b1);
        wait_cycle(38);
        req = 4'b0000;

        // ptr=3, req=0101: wraps to 0, then skips 1 to reach 2.
        wait_cycle(40);
        req    = 4'b0101;
        req_x1 = 4'b0001;
        push_job(0, 1, 41, 4, 0, 1'b1);
        push_job(2, 0, 47, 4, 0, 1'b1);
        wait_cycle(51);
        req = 4'b0000;

        // req=1000: winner 3 twice (second time from ptr=0), ptr wraps to 0.
        wait_cycle(53);
        req    = 4'b1000;
        req_x1 = 4'b1000;
        push_job(3, 1, 54, 4, 0, 1'b1);
        push_job(3, 1, 60, 4, 0, 1'b1);
        wait_cycle(64);
        req = 4'b1001;
        push_job(0, 0, 66, 4, 0, 1'b1);

        // Abort: requester 1 drops in its 2nd RUN cycle.
        wait_cycle(70);
        req    = 4'b0010;
        req_x1 = 4'b0010;
        push_job(1, 1, 72, 2, 1, 1'b1);
        wait_cycle(73);
        req = 4'b0000;

        // ptr=2 after abort; drop in the final RUN cycle still aborts.
        wait_cycle(75);
        req    = 4'b1111;
        req_x1 = 4'b0001;
        push_job(2, 0, 76, 4, 1, 1'b1);
        wait_cycle(79);
        req = 4'b1011;

        // Reset in the 3rd RUN cycle of requester 3's job: no done.
        push_job(3, 0, 82, 4, 0, 1'b0);
        wait_cycle(84);
        reset = 1'b1;
        wait_cycle(85);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_gnt_id", 32'(gnt_id), 32'd0);
        reset = 1'b0;
        // ptr back at 0: requester 0 wins over 1 and 3.
        push_job(0, 1, 86, 4, 0, 1'b1);
        wait_cycle(90);
        req = 4'b0000;

        wait_cycle(95);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fsm_rr_scheduler
